ranging_sequencer: RTL and testbench

Sequences the ultrasonic ranger's ping cycle: it drives `trig`, measures the echo pulse width in `clk` cycles, enforces the inter-ping period and echo timeout, and averages 2^AVG_LOG2 good samples into one result. The result is delivered over a valid/ready handshake to the reading/history logic. It sits between the `echo`/`trig` pins and the set_reading path, on the 12 MHz `clk` domain.

---
 rtl/ranging_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_ranging_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ranging_sequencer.sv
// Ultrasonic ranger ping sequencer: drives trig, times the echo pulse, enforces
// the ping period and echo timeouts, and averages good samples into one result.
module ranging_sequencer #(
    parameter int TRIG_CYCLES    = 120,
    parameter int TIMEOUT_CYCLES = 360_000,
    parameter int PERIOD_CYCLES  = 720_000,
    parameter int AVG_LOG2       = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        echo,
    output logic        trig,
    output logic        busy,
    output logic [31:0] result_cycles,
    output logic        result_valid,
    input  logic        result_ready,
    output logic        overrun,
    output logic        timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RISE,
        S_MEASURE,
        S_HOLDOFF
    } state_t;

    localparam int                AW        = 32 + AVG_LOG2;
    localparam logic [31:0]       TRIG_LAST = 32'(TRIG_CYCLES - 1);
    localparam logic [31:0]       TMO       = 32'(TIMEOUT_CYCLES);
    localparam logic [31:0]       TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]       PERIOD    = 32'(PERIOD_CYCLES);
    localparam logic [AVG_LOG2:0] NS_ONE    = (AVG_LOG2 + 1)'(1);
    localparam logic [AVG_LOG2:0] NS_LAST   = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);

    state_t            state_q, state_d;
    logic              sync1_q, sync1_d;
    logic              echo_s_q, echo_s_d;
    logic              echo_prev_q, echo_prev_d;
    logic [31:0]       phase_q, phase_d;
    logic [31:0]       period_q, period_d;
    logic [31:0]       width_q, width_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [AVG_LOG2:0] nsamp_q, nsamp_d;
    logic [31:0]       result_q, result_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic              timeout_q, timeout_d;

    logic              rise, fall, sample_add, complete;
    logic [AW-1:0]     acc_sum;

    always_comb begin
        state_d     = state_q;
        sync1_d     = echo;
        echo_s_d    = sync1_q;
        echo_prev_d = echo_s_q;
        phase_d     = phase_q;
        width_d     = width_q;
        acc_d       = acc_q;
        nsamp_d     = nsamp_q;
        result_d    = result_q;
        valid_d     = valid_q;
        overrun_d   = 1'b0;
        timeout_d   = 1'b0;
        sample_add  = 1'b0;
        complete    = 1'b0;

        rise = echo_s_q & ~echo_prev_q;
        fall = ~echo_s_q & echo_prev_q;

        // Saturates so a stuck-high echo in HOLDOFF cannot wrap it back below PERIOD.
        period_d = (period_q == '1) ? period_q : period_q + 32'd1;

        case (state_q)
            S_IDLE: begin
                acc_d   = '0;
                nsamp_d = '0;
                if (en) begin
                    state_d  = S_TRIG;
                    phase_d  = '0;
                    period_d = 32'd1;
                end
            end
            S_TRIG: begin
                if (phase_q == TRIG_LAST) begin
                    state_d = S_WAIT_RISE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 32'd1;
                end
            end
            S_WAIT_RISE: begin
                if (rise) begin
                    state_d = S_MEASURE;
                    width_d = 32'd1;
                end else if (phase_q == TMO_LAST) begin
                    state_d   = S_HOLDOFF;
                    timeout_d = 1'b1;
                end else begin
                    phase_d = phase_q + 32'd1;
                end
            end
            S_MEASURE: begin
                if (fall) begin
                    state_d    = S_HOLDOFF;
                    sample_add = 1'b1;
                end else if (width_q >= TMO) begin
                    state_d   = S_HOLDOFF;
                    timeout_d = 1'b1;
                end else if (echo_s_q) begin
                    width_d = width_q + 32'd1;
                end
            end
            S_HOLDOFF: begin
                // period_q counts the trig rise cycle as 1, so exiting at PERIOD
                // spaces trig rises exactly PERIOD cycles apart.
                if (period_q >= PERIOD && !echo_s_q) begin
                    if (en) begin
                        state_d  = S_TRIG;
                        phase_d  = '0;
                        period_d = 32'd1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        acc_sum = acc_q + AW'(width_q);
        if (sample_add) begin
            if (nsamp_q == NS_LAST) begin
                result_d = acc_sum[AVG_LOG2 +: 32];
                acc_d    = '0;
                nsamp_d  = '0;
                complete = 1'b1;
            end else begin
                acc_d   = acc_sum;
                nsamp_d = nsamp_q + NS_ONE;
            end
        end

        if (complete) begin
            valid_d   = 1'b1;
            overrun_d = valid_q & ~result_ready;
        end else if (valid_q && result_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b0;
            echo_s_q    <= 1'b0;
            echo_prev_q <= 1'b0;
            phase_q     <= '0;
            period_q    <= '0;
            width_q     <= '0;
            acc_q       <= '0;
            nsamp_q     <= '0;
            result_q    <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            echo_s_q    <= echo_s_d;
            echo_prev_q <= echo_prev_d;
            phase_q     <= phase_d;
            period_q    <= period_d;
            width_q     <= width_d;
            acc_q       <= acc_d;
            nsamp_q     <= nsamp_d;
            result_q    <= result_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
        end
    end

    assign trig          = (state_q == S_TRIG);
    assign busy          = (state_q != S_IDLE);
    assign result_cycles = result_q;
    assign result_valid  = valid_q;
    assign overrun       = overrun_q;
    assign timeout       = timeout_q;

endmodule

// File: tb/tb_ranging_sequencer.sv
// Directed bench for ranging_sequencer with a short ping period; the echo pin is
// driven relative to observed trig pulses and results are checked against hand values.
module tb_ranging_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        echo = 1'b0;
    logic        trig, busy, result_valid, overrun, timeout;
    logic        result_ready = 1'b1;
    logic [31:0] result_cycles;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_rise = 0, prev_rise = 0, fall_cyc = 0;

    // negedge monitor state
    int  res_events = 0, tmo_cnt = 0, tmo_cyc = 0, ovr_cnt = 0;
    int  vlen = 0, last_vlen = 0, tlen = 0, last_tlen = 0;
    int  rise_cnt = 0;
    logic [31:0] last_result = '0;
    logic rv_prev = 1'b0, t_prev = 1'b0;

    ranging_sequencer #(
        .TRIG_CYCLES(4), .TIMEOUT_CYCLES(100), .PERIOD_CYCLES(250), .AVG_LOG2(2)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .echo(echo), .trig(trig), .busy(busy),
        .result_cycles(result_cycles), .result_valid(result_valid),
        .result_ready(result_ready), .overrun(overrun), .timeout(timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        rv_prev <= result_valid;
        t_prev  <= trig;
        if (result_valid) vlen <= vlen + 1;
        else if (rv_prev) begin last_vlen <= vlen; vlen <= 0; end
        if (result_valid && !rv_prev) begin
            res_events  <= res_events + 1;
            last_result <= result_cycles;
        end
        if (trig) tlen <= tlen + 1;
        else if (t_prev) begin last_tlen <= tlen; tlen <= 0; end
        if (trig && !t_prev) rise_cnt <= rise_cnt + 1;
        if (timeout) begin tmo_cnt <= tmo_cnt + 1; tmo_cyc <= cyc; end
        if (overrun) ovr_cnt <= ovr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_trig(input logic lvl, input int bound, input string tag);
        int n = 0;
        while (trig !== lvl && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(trig), 32'(lvl));
    endtask

    // One ping: echo rises dly cycles after trig falls and stays high w cycles (w=0: silent).
    task automatic ping(input int dly, input int w);
        wait_trig(1'b1, 1000, "trig_rise");
        prev_rise = last_rise;
        last_rise = cyc;
        wait_trig(1'b0, 20, "trig_fall");
        fall_cyc = cyc;
        if (w > 0) begin
            repeat (dly) @(negedge clk);
            echo = 1'b1;
            repeat (w) @(negedge clk);
            echo = 1'b0;
        end
    endtask

    initial begin
        int t0, x, rc;
        repeat (3) @(negedge clk);
        chk("rst_trig", 32'(trig), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(result_valid), 0);
        chk("rst_result", result_cycles, 0);
        chk("rst_ovr_tmo", 32'({overrun, timeout}), 0);
        rst = 1'b0;
        @(negedge clk);

        // trig follows en by one cycle
        en = 1'b1;
        @(negedge clk);
        chk("en_to_trig", 32'(trig), 1);
        chk("en_busy", 32'(busy), 1);

        // steady state, width 30
        repeat (4) ping(10, 30);
        repeat (6) @(negedge clk);
        chk("ss_events", 32'(res_events), 1);
        chk("ss_result", last_result, 30);
        chk("ss_valid_len", 32'(last_vlen), 1);
        chk("ss_trig_len", 32'(last_tlen), 4);
        chk("ss_spacing", 32'(last_rise - prev_rise), 250);

        // truncating average: 47>>2
        ping(10, 10); ping(10, 11); ping(10, 12); ping(10, 14);
        repeat (6) @(negedge clk);
        chk("trunc_events", 32'(res_events), 2);
        chk("trunc_result", last_result, 11);

        // silent ping is dropped; result needs five pings
        ping(10, 20);
        ping(0, 0);
        repeat (110) @(negedge clk);
        chk("tmo_count", 32'(tmo_cnt), 1);
        chk("tmo_delay", 32'(tmo_cyc - fall_cyc), 100);
        ping(10, 24); ping(10, 28);
        repeat (6) @(negedge clk);
        chk("tmo_no_result", 32'(res_events), 2);
        ping(10, 32);
        repeat (6) @(negedge clk);
        chk("tmo_events", 32'(res_events), 3);
        chk("tmo_result", last_result, 26);
        ping(10, 120);
        repeat (6) @(negedge clk);
        chk("long_echo_tmo", 32'(tmo_cnt), 2);

        // overrun with result_ready low across two completions
        result_ready = 1'b0;
        repeat (4) ping(10, 40);
        repeat (6) @(negedge clk);
        chk("ovr_first", last_result, 40);
        chk("ovr_none_yet", 32'(ovr_cnt), 0);
        repeat (4) ping(10, 50);
        repeat (6) @(negedge clk);
        chk("ovr_count", 32'(ovr_cnt), 1);
        chk("ovr_result", result_cycles, 50);
        chk("ovr_valid_held", 32'(result_valid), 1);
        chk("ovr_events", 32'(res_events), 4);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        chk("accept_drop", 32'(result_valid), 0);
        result_ready = 1'b1;

        // en dropped mid-measure: ping completes, then IDLE
        wait_trig(1'b1, 1000, "en_drop_rise");
        wait_trig(1'b0, 20, "en_drop_fall");
        repeat (10) @(negedge clk);
        echo = 1'b1;
        repeat (5) @(negedge clk);
        en = 1'b0;
        chk("en_drop_busy", 32'(busy), 1);
        repeat (25) @(negedge clk);
        echo = 1'b0;
        rc = rise_cnt;
        repeat (300) @(negedge clk);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_no_trig", 32'(rise_cnt), 32'(rc));

        // reset during TRIG
        en = 1'b1;
        wait_trig(1'b1, 10, "rst_trig_rise");
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_trig", 32'(trig), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        rst = 1'b0;

        // reset with a pending result
        result_ready = 1'b0;
        repeat (4) ping(10, 30);
        repeat (6) @(negedge clk);
        chk("pend_valid", 32'(result_valid), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("pend_rst_valid", 32'(result_valid), 0);
        chk("pend_rst_result", result_cycles, 0);
        rst = 1'b0;
        result_ready = 1'b1;

        // echo stuck high through HOLDOFF delays the next trig
        wait_trig(1'b1, 1000, "stuck_rise");
        t0 = cyc;
        wait_trig(1'b0, 20, "stuck_fall");
        repeat (10) @(negedge clk);
        echo = 1'b1;
        while (cyc < t0 + 300) @(negedge clk);
        chk("stuck_holds", 32'(trig), 0);
        echo = 1'b0;
        x = cyc;
        wait_trig(1'b1, 100, "stuck_next_rise");
        chk("stuck_release", 32'(cyc - x), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
